division: RTL and testbench

- Sequential unsigned integer divider: computes quotient Res = floor(A/B) and remainder Rem = A mod B for WIDTH-bit operands.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Operands enter through a start/done handshake. Results are registered and held until the next operation completes.
- Used as the arithmetic helper for datapath blocks that need integer division, e.g. percentages and averages of vote counts.

---
 rtl/division.sv | 110 +++++++++++
 tb/tb_division.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/division.sv
// Sequential unsigned divider: radix-2 restoring, one quotient bit per clock.
// Results are registered and held until the next operation completes.
module division #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] Rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;      // dividend shifts out MSB first, quotient shifts in at LSB
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   prem_q;   // one extra bit so the shifted remainder cannot overflow
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   prem_sh;
    logic [WIDTH:0]   prem_diff;
    logic             q_bit;
    logic             load;

    // One restoring step: shift in next dividend bit and try subtracting the divisor
    always_comb begin
        prem_sh   = {prem_q[WIDTH-1:0], a_q[WIDTH-1]};
        prem_diff = prem_sh - {1'b0, b_q};
        q_bit     = (prem_sh >= {1'b0, b_q});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            Res         <= '0;
            Rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_d == S_RUN);
            done <= 1'b0;
            if (load) begin
                a_q    <= A;
                b_q    <= B;
                prem_q <= '0;
                cnt_q  <= CW'(WIDTH - 1);
            end
            if (state_q == S_RUN) begin
                a_q    <= {a_q[WIDTH-2:0], q_bit};
                prem_q <= q_bit ? prem_diff : prem_sh;
                cnt_q  <= cnt_q - CW'(1);
            end
            // B=0 falls out naturally: every step subtracts zero, giving all-ones and Rem=A
            if (state_q == S_DONE) begin
                Res         <= a_q;
                Rem         <= prem_q[WIDTH-1:0];
                div_by_zero <= (b_q == '0);
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_division.sv
// Directed testbench for the division block with hand-computed expected values.
module tb_division;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Res;
    logic [WIDTH-1:0] Rem;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    division #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Res         (Res),
        .Rem         (Rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the done pulse, counting edges and busy samples; bounded
    task automatic wait_done(input string tag, output int lat, output int bsy);
        lat = 0;
        bsy = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done) break;
            if (busy) bsy++;
        end
        if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input int a, input int b,
                          input int e_res, input int e_rem, input int e_dz);
        int lat, bsy;
        A = WIDTH'(a);
        B = WIDTH'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        A = '1;
        B = '1;
        wait_done(tag, lat, bsy);
        chk({tag, "_lat"},  32'(lat), WIDTH + 1);
        chk({tag, "_busy"}, 32'(bsy), WIDTH);
        chk({tag, "_res"},  32'(Res), 32'(e_res));
        chk({tag, "_rem"},  32'(Rem), 32'(e_rem));
        chk({tag, "_dz"},   32'(div_by_zero), 32'(e_dz));
        tick();
        chk({tag, "_drop"}, 32'(done), 32'd0);
        chk({tag, "_keep"}, 32'(Res), 32'(e_res));
    endtask

    int va[12]  = '{128, 100, 201, 90, 70, 16, 255, 37, 9, 5,   255, 0};
    int vb[12]  = '{127, 10,  40,  9,  10, 3,  5,   0,  3, 200, 1,   7};
    int vr[12]  = '{1,   10,  5,   10, 7,  5,  51,  255, 3, 0,  255, 0};
    int vm[12]  = '{1,   0,   1,   0,  0,  1,  0,   37, 0, 5,   0,   0};
    int vz[12]  = '{0,   0,   0,   0,  0,  0,  0,   1,  0, 0,   0,   0};

    initial begin
        int lat, bsy, seen;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) tick();
        chk("rst_res",  32'(Res), 0);
        chk("rst_rem",  32'(Rem), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dz",   32'(div_by_zero), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++)
            run_op($sformatf("op%0d", i), va[i], vb[i], vr[i], vm[i], vz[i]);

        // start pulse during RUN must be ignored
        A = 8'd100; B = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        A = 8'd50; B = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        A = '0; B = '0;
        wait_done("ign", lat, bsy);
        chk("ign_res", 32'(Res), 10);
        chk("ign_rem", 32'(Rem), 0);
        tick();
        chk("ign_noextra", 32'(busy), 0);

        // start held high: done pulses every WIDTH+2 edges
        A = 8'd100; B = 8'd10; start = 1'b1;
        wait_done("held0", lat, bsy);
        wait_done("held1", lat, bsy);
        chk("held_period1", 32'(lat), WIDTH + 2);
        wait_done("held2", lat, bsy);
        chk("held_period2", 32'(lat), WIDTH + 2);
        start = 1'b0;
        chk("held_res", 32'(Res), 10);
        tick();

        // reset mid-run aborts with no done pulse
        A = 8'd200; B = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("mid_hold", 32'(Res), 10);
        rst_n = 1'b0;
        #1;
        chk("ar_res",  32'(Res), 0);
        chk("ar_rem",  32'(Rem), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_done", 32'(done), 0);
        chk("ar_dz",   32'(div_by_zero), 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done || busy) seen++;
        end
        chk("ar_nodone", 32'(seen), 0);
        run_op("post_rst", 200, 7, 28, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
